alu_stack_driver: RTL and testbench
===================================

// Module: alu_stack_driver
// PURPOSE
//  Issue side of the 16-bit ALU. Owns the processor data stack and accepts stack commands over a valid/ready handshake.
//  For ALU commands it pops operands, drives Oper/A/B into the combinational alu, captures ALU_Out and pushes the result.
//  Sits between the instruction decoder (command source) and the alu instance.
// PARAMETERS
//  DEPTH  8  data stack entries, 16 bits each; legal range 2..256
// PORTS
//  clk          in   1   system clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high reset
//  Cmd_Valid    in   1   command present
//  Cmd_Ready    out  1   block can accept a command (high only in IDLE)
//  Cmd_Kind     in   2   00 push Cmd_Imm, 01 binary ALU op, 10 unary ALU op, 11 pop/discard
//  Cmd_Oper     in   4   ALU opcode for kinds 01/10 (same encoding as alu Oper)
//  Cmd_Imm      in   16  immediate for push
//  Oper         out  4   to alu Oper (registered)
//  A            out  16  to alu A (registered)
//  B            out  16  to alu B (registered)
//  ALU_Out      in   16  from alu result
//  Top          out  16  stack[Depth-1] when Depth>0, else 0
//  Depth        out  $clog2(DEPTH+1)  current entry count
//  Empty/Full   out  1   Depth==0 / Depth==DEPTH
//  Done         out  1   one-cycle pulse per completed accepted command
//  Err_Code     out  2   status of the command signalled by Done: 0 ok, 1 underflow, 2 stack full, 3 arith ovf
//  Err          out  1   sticky OR of all nonzero Err_Code; cleared only by reset
// BEHAVIOUR
//  Interface is fixed: one clock (clk); reset is synchronous and active-high (reset).
//  Reset: state IDLE, Depth=0, Oper=0, A=0, B=0, Done=0, Err_Code=0, Err=0. Top=0, Empty=1.
//   Stack contents are don't-care after reset.
//  Handshake: accept at cycle T iff Cmd_Valid&&Cmd_Ready. Cmd_* sampled only at accept; ignored otherwise.
//  FSM: IDLE -> EXEC -> WB -> IDLE for ALU kinds. Push, pop and error cases stay in IDLE.
//  Push (00): if Full, Err_Code=2 and stack is unchanged. Else write stack[Depth]=Cmd_Imm and increment Depth.
//   Done=1 at T+1.
//  Pop (11): if Empty, Err_Code=1. Else decrement Depth. Done=1 at T+1.
//  Binary (01): requires Depth>=2, else Err_Code=1 with Done at T+1 and no state change.
//   At accept: A<=stack[Depth-2] (deeper entry), B<=stack[Depth-1] (top), Oper<=Cmd_Oper.
//   T+1 EXEC: alu is combinational; capture ALU_Out into the result register.
//   T+2 WB: stack[Depth-2]<=result, Depth-=1, Done=1, back to IDLE. Next accept is possible at T+3.
//  Unary (10): requires Depth>=1, else Err_Code=1. At accept: A<=stack[Depth-1], B<=0.
//   WB overwrites stack[Depth-1]; Depth is unchanged. Timing is the same as binary.
//  Oper/A/B update only on ALU-command accept; they hold their values otherwise.
//  Opcodes are passed through unchecked; undefined codes push whatever ALU_Out presents.
//  Binary and unary ops never overflow the stack (net change is -1 and 0).
//  Top/Depth/Empty/Full reflect state after the edge; a pushed value is visible at T+1.
//  Reset mid-operation (EXEC/WB): the command is abandoned with no Done pulse, and all reset values apply.
//  Err_Code holds its value until the next Done.
// CONFIGURATION
//  ALU_DRV_OVF_CHECK_EN defined: in WB, for Oper 0000 (add) or 0001 (sub), Err_Code=3 on signed 16-bit overflow.
//   add overflows when A[15]==B[15] && R[15]!=A[15]; sub overflows when A[15]!=B[15] && R[15]!=A[15].
//   The result is still pushed, and Err is set.
//  Undefined: no overflow logic; Err_Code never equals 3.
// TESTING
//  Reset, then push 0x0005 and push 0x0003 -> Depth=2, Top=0x0003, Done pulses at T+1 each, Err_Code=0.
//  Binary 0001 (sub) on [5,3] -> A=5, B=3 at T+1; Done at T+2; Top=0x0002, Depth=1; Cmd_Ready low for T+1..T+2.
//  Binary 1001 on [2,7] (B<A?) -> Top=0; then unary 1000 on [0] -> Top=1, Depth unchanged.
//  Fill DEPTH=8 entries, push a 9th -> Err_Code=2, Err=1, Depth=8. Binary op on an empty stack -> Err_Code=1, Depth=0.
//  Push 0x7FFF and 0x0001, binary 0000 -> Top=0x8000; Err_Code=3 with ALU_DRV_OVF_CHECK_EN, else 0.
//  Assert reset during EXEC -> no Done, Depth=0, Empty=1, A=B=Oper=0, Cmd_Ready=1 next cycle.

Source files
------------

// File: rtl/alu_stack_driver_if.sv
// Command handshake between the instruction decoder (master) and the ALU stack driver (slave).
// A command transfers on any rising clk edge where Cmd_Valid and Cmd_Ready are both high.
interface alu_stack_driver_if;
    logic        Cmd_Valid;
    logic        Cmd_Ready;
    logic [1:0]  Cmd_Kind;
    logic [3:0]  Cmd_Oper;
    logic [15:0] Cmd_Imm;

    modport master (output Cmd_Valid, Cmd_Kind, Cmd_Oper, Cmd_Imm, input Cmd_Ready);
    modport slave  (input Cmd_Valid, Cmd_Kind, Cmd_Oper, Cmd_Imm, output Cmd_Ready);
endinterface

// File: rtl/alu_stack_driver.sv
// Data stack plus ALU issue sequencer: push/pop complete in 1 cycle, ALU ops in 2 (IDLE->EXEC->WB).
// Backpressure: Cmd_Ready is high only in IDLE. Optional macro ALU_DRV_OVF_CHECK_EN flags signed add/sub overflow.
module alu_stack_driver #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    alu_stack_driver_if.slave          cmd,
    output logic [3:0]                 Oper,
    output logic [15:0]                A,
    output logic [15:0]                B,
    input  logic [15:0]                ALU_Out,
    output logic [15:0]                Top,
    output logic [$clog2(DEPTH+1)-1:0] Depth,
    output logic                       Empty,
    output logic                       Full,
    output logic                       Done,
    output logic [1:0]                 Err_Code,
    output logic                       Err
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t          state_q, state_d;
    logic [15:0]     stack_q [DEPTH];
    logic [DW-1:0]   depth_q, depth_d;
    logic [3:0]      oper_q, oper_d;
    logic [15:0]     a_q, a_d, b_q, b_d;
    logic            bin_q, bin_d;
    logic            done_q, done_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            err_q, err_d;

    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [15:0]     wr_dat;
    logic [DW-1:0]   dm1, dm2;
    logic [IW-1:0]   top_idx, sec_idx, push_idx;
    logic            accept, is_bin, is_alu, enough, alu_go, ovf;

    assign dm1      = depth_q - DW'(1);
    assign dm2      = depth_q - DW'(2);
    assign top_idx  = dm1[IW-1:0];
    assign sec_idx  = dm2[IW-1:0];
    assign push_idx = depth_q[IW-1:0];

    assign accept = cmd.Cmd_Valid && cmd.Cmd_Ready;
    assign is_bin = (cmd.Cmd_Kind == 2'b01);
    assign is_alu = (cmd.Cmd_Kind == 2'b01) || (cmd.Cmd_Kind == 2'b10);
    assign enough = is_bin ? (depth_q >= DW'(2)) : (depth_q >= DW'(1));
    assign alu_go = accept && is_alu && enough;

`ifdef ALU_DRV_OVF_CHECK_EN
    assign ovf = ((oper_q == 4'b0000) && (a_q[15] == b_q[15]) && (ALU_Out[15] != a_q[15])) ||
                 ((oper_q == 4'b0001) && (a_q[15] != b_q[15]) && (ALU_Out[15] != a_q[15]));
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (alu_go) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd.Cmd_Ready = (state_q == S_IDLE);
    end

    // The ALU result is captured and written into the stack on the EXEC->WB edge, so the
    // WB cycle (with Done high) already shows the updated Top/Depth, just like a push.
    always_comb begin
        depth_d    = depth_q;
        oper_d     = oper_q;
        a_d        = a_q;
        b_d        = b_q;
        bin_d      = bin_q;
        done_d     = 1'b0;
        err_code_d = err_code_q;
        wr_en      = 1'b0;
        wr_idx     = push_idx;
        wr_dat     = cmd.Cmd_Imm;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd.Cmd_Kind)
                        2'b00: begin
                            done_d = 1'b1;
                            if (Full) begin
                                err_code_d = 2'd2;
                            end else begin
                                err_code_d = 2'd0;
                                wr_en      = 1'b1;
                                depth_d    = depth_q + DW'(1);
                            end
                        end
                        2'b11: begin
                            done_d = 1'b1;
                            if (Empty) begin
                                err_code_d = 2'd1;
                            end else begin
                                err_code_d = 2'd0;
                                depth_d    = dm1;
                            end
                        end
                        default: begin
                            if (enough) begin
                                oper_d = cmd.Cmd_Oper;
                                a_d    = is_bin ? stack_q[sec_idx] : stack_q[top_idx];
                                b_d    = is_bin ? stack_q[top_idx] : 16'h0000;
                                bin_d  = is_bin;
                            end else begin
                                done_d     = 1'b1;
                                err_code_d = 2'd1;
                            end
                        end
                    endcase
                end
            end
            S_EXEC: begin
                wr_en      = 1'b1;
                wr_idx     = bin_q ? sec_idx : top_idx;
                wr_dat     = ALU_Out;
                depth_d    = bin_q ? dm1 : depth_q;
                done_d     = 1'b1;
                err_code_d = ovf ? 2'd3 : 2'd0;
            end
            default: ;
        endcase
        err_d = err_q | (done_d && (err_code_d != 2'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q    <= '0;
            oper_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            bin_q      <= 1'b0;
            done_q     <= 1'b0;
            err_code_q <= '0;
            err_q      <= 1'b0;
        end else begin
            depth_q    <= depth_d;
            oper_q     <= oper_d;
            a_q        <= a_d;
            b_q        <= b_d;
            bin_q      <= bin_d;
            done_q     <= done_d;
            err_code_q <= err_code_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) stack_q[wr_idx] <= wr_dat;
    end

    assign Oper     = oper_q;
    assign A        = a_q;
    assign B        = b_q;
    assign Depth    = depth_q;
    assign Empty    = (depth_q == '0);
    assign Full     = (depth_q == DW'(DEPTH));
    assign Top      = Empty ? 16'h0000 : stack_q[top_idx];
    assign Done     = done_q;
    assign Err_Code = err_code_q;
    assign Err      = err_q;
endmodule

// File: tb/tb_alu_stack_driver.sv
// Directed bench for alu_stack_driver (DEPTH=8) with a small behavioural ALU attached.
// Expected values are hand-computed constants.
module tb_alu_stack_driver;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  Oper;
    logic [15:0] A, B, ALU_Out, Top;
    logic [3:0]  Depth;
    logic        Empty, Full, Done, Err;
    logic [1:0]  Err_Code;

    int n_cmp = 0;
    int n_mis = 0;

    alu_stack_driver_if cmd_if();

    alu_stack_driver #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cmd(cmd_if),
        .Oper(Oper), .A(A), .B(B), .ALU_Out(ALU_Out),
        .Top(Top), .Depth(Depth), .Empty(Empty), .Full(Full),
        .Done(Done), .Err_Code(Err_Code), .Err(Err)
    );

    always #5 clk = ~clk;

    // 0 add, 1 sub, 8 increment, 9 (B<A), others xor
    always_comb begin
        case (Oper)
            4'h0:    ALU_Out = A + B;
            4'h1:    ALU_Out = A - B;
            4'h8:    ALU_Out = A + 16'd1;
            4'h9:    ALU_Out = {15'd0, (B < A)};
            default: ALU_Out = A ^ B;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the accept edge, i.e. in cycle T+1.
    task automatic send(input logic [1:0] k, input logic [3:0] op, input logic [15:0] imm);
        int w = 0;
        @(negedge clk);
        while (!cmd_if.Cmd_Ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_if.Cmd_Ready) chk("ready_timeout", 32'd0, 32'd1);
        cmd_if.Cmd_Kind  = k;
        cmd_if.Cmd_Oper  = op;
        cmd_if.Cmd_Imm   = imm;
        cmd_if.Cmd_Valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_if.Cmd_Valid = 1'b0;
        cmd_if.Cmd_Imm   = 16'hDEAD;
    endtask

    initial begin
        cmd_if.Cmd_Valid = 1'b0;
        cmd_if.Cmd_Kind  = 2'b00;
        cmd_if.Cmd_Oper  = 4'h0;
        cmd_if.Cmd_Imm   = 16'h0000;
        repeat (3) step();
        reset = 1'b0;
        step();

        chk("rst_depth", Depth, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_top", Top, 0);
        chk("rst_done", Done, 0);
        chk("rst_errc", Err_Code, 0);
        chk("rst_err", Err, 0);
        chk("rst_abo", {A, B}, 0);
        chk("rst_oper", Oper, 0);
        chk("rst_ready", cmd_if.Cmd_Ready, 1);

        send(2'b00, 4'h0, 16'h0005);
        chk("push5_done", Done, 1);
        chk("push5_top", Top, 16'h0005);
        send(2'b00, 4'h0, 16'h0003);
        chk("push3_done", Done, 1);
        chk("push3_depth", Depth, 2);
        chk("push3_top", Top, 16'h0003);
        chk("push3_errc", Err_Code, 0);
        step();
        chk("done_pulse", Done, 0);

        send(2'b01, 4'h1, 16'h0000);
        chk("sub_A", A, 16'h0005);
        chk("sub_B", B, 16'h0003);
        chk("sub_oper", Oper, 4'h1);
        chk("sub_t1_rdy", cmd_if.Cmd_Ready, 0);
        chk("sub_t1_done", Done, 0);
        step();
        chk("sub_t2_done", Done, 1);
        chk("sub_t2_rdy", cmd_if.Cmd_Ready, 0);
        chk("sub_top", Top, 16'h0002);
        chk("sub_depth", Depth, 1);
        chk("sub_errc", Err_Code, 0);
        step();
        chk("sub_t3_rdy", cmd_if.Cmd_Ready, 1);
        chk("sub_t3_done", Done, 0);
        chk("hold_A", A, 16'h0005);

        send(2'b00, 4'h0, 16'h0007);
        send(2'b01, 4'h9, 16'h0000);
        step();
        chk("lt_top", Top, 16'h0000);
        chk("lt_depth", Depth, 1);
        send(2'b10, 4'h8, 16'h0000);
        chk("inc_A", A, 16'h0000);
        chk("inc_B", B, 16'h0000);
        step();
        chk("inc_done", Done, 1);
        chk("inc_top", Top, 16'h0001);
        chk("inc_depth", Depth, 1);

        for (int i = 1; i < DEPTH; i++) send(2'b00, 4'h0, 16'h0100 + 16'(i));
        chk("fill_full", Full, 1);
        chk("fill_top", Top, 16'h0107);
        send(2'b00, 4'h0, 16'hBEEF);
        chk("ovfl_done", Done, 1);
        chk("ovfl_errc", Err_Code, 2);
        chk("ovfl_err", Err, 1);
        chk("ovfl_depth", Depth, 8);
        chk("ovfl_top", Top, 16'h0107);

        send(2'b11, 4'h0, 16'h0000);
        chk("pop_errc", Err_Code, 0);
        chk("pop_top", Top, 16'h0106);
        for (int i = 0; i < DEPTH - 1; i++) send(2'b11, 4'h0, 16'h0000);
        chk("drain_empty", Empty, 1);
        chk("drain_top", Top, 0);
        send(2'b11, 4'h0, 16'h0000);
        chk("popund_errc", Err_Code, 1);
        chk("popund_depth", Depth, 0);
        send(2'b00, 4'h0, 16'h0042);
        send(2'b01, 4'h0, 16'h0000);
        chk("binund_done", Done, 1);
        chk("binund_errc", Err_Code, 1);
        chk("binund_rdy", cmd_if.Cmd_Ready, 1);
        chk("binund_depth", Depth, 1);
        chk("binund_top", Top, 16'h0042);
        send(2'b11, 4'h0, 16'h0000);
        send(2'b10, 4'h8, 16'h0000);
        chk("unund_errc", Err_Code, 1);
        chk("unund_depth", Depth, 0);
        chk("sticky_err", Err, 1);

        send(2'b00, 4'h0, 16'h7FFF);
        send(2'b00, 4'h0, 16'h0001);
        send(2'b01, 4'h0, 16'h0000);
        step();
        chk("add_done", Done, 1);
        chk("add_top", Top, 16'h8000);
        chk("add_depth", Depth, 1);
`ifdef ALU_DRV_OVF_CHECK_EN
        chk("add_errc", Err_Code, 3);
`else
        chk("add_errc", Err_Code, 0);
`endif

        send(2'b00, 4'h0, 16'h0011);
        send(2'b01, 4'h2, 16'h0000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstx_done", Done, 0);
        chk("rstx_depth", Depth, 0);
        chk("rstx_empty", Empty, 1);
        chk("rstx_abo", {12'd0, Oper, A, B}, 0);
        chk("rstx_rdy", cmd_if.Cmd_Ready, 1);
        chk("rstx_err", Err, 0);
        step();
        chk("rstx_done2", Done, 0);

        send(2'b00, 4'h0, 16'h1234);
        chk("post_top", Top, 16'h1234);
        chk("post_depth", Depth, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end
endmodule
